// File: rtl/divisor_planif_pkg.sv
// Shared types and helpers for the divider round-robin scheduler.
//   tag_t    : per-operation tracking tag carried alongside the divider pipeline
//   latencia : divider latency in cycles for a given operand width
package divisor_planif_pkg;

  // Tag id is sized for the largest supported requester count (16).
  localparam int unsigned N_REQ_MAX = 16;
  localparam int unsigned ID_W      = $clog2(N_REQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            dz;
  } tag_t;

  function automatic int unsigned latencia(input int unsigned tamanyo);
    return 2 * tamanyo + 1;
  endfunction

endpackage

// File: rtl/divisor_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
//   CLK, RSTa : clock, async active-low reset
//   req       : request vector
//   en        : grant enable (no grant when low)
//   grant     : combinational one-hot grant
module divisor_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_n;
  logic             found;
  int unsigned      idx;

  // Scan from rr_ptr with wrap-around; pointer moves just past the winner.
  always_comb begin
    grant = '0;
    ptr_n = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_n      = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) rr_ptr <= '0;
    else       rr_ptr <= ptr_n;
  end

endmodule

// File: rtl/divisor_seg_planificador.sv
// Round-robin scheduler sharing one fixed-latency pipelined divider among N_REQ clients.
//   CLK, RSTa                  : clock, async active-low reset
//   en                         : grant enable (drain when low)
//   req_valid/req_num/req_den  : requests, operands packed per requester
//   req_ready                  : combinational one-hot grant
//   div_start/div_num/div_den  : registered issue to divider
//   div_coc/div_res/div_done   : divider results
//   rsp_valid/rsp_coc/rsp_res/rsp_dz : registered response to owner
//   busy                       : operations outstanding
//   err_tag                    : sticky div_done / tag misalignment
module divisor_seg_planificador
  import divisor_planif_pkg::*;
#(
  parameter int unsigned TAMANYO  = 32,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned LATENCIA = latencia(TAMANYO)
) (
  input  logic                     CLK,
  input  logic                     RSTa,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*TAMANYO-1:0] req_num,
  input  logic [N_REQ*TAMANYO-1:0] req_den,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     div_start,
  output logic [TAMANYO-1:0]       div_num,
  output logic [TAMANYO-1:0]       div_den,
  input  logic [TAMANYO-1:0]       div_coc,
  input  logic [TAMANYO-1:0]       div_res,
  input  logic                     div_done,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [TAMANYO-1:0]       rsp_coc,
  output logic [TAMANYO-1:0]       rsp_res,
  output logic                     rsp_dz,
  output logic                     busy,
  output logic                     err_tag
);

  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   rsp_valid_n;
  logic               accept_c;
  logic               any_tag_c;
  logic               busy_c;
  logic [TAMANYO-1:0] sel_num;
  logic [TAMANYO-1:0] sel_den;
  logic [ID_W-1:0]    sel_id;
  tag_t               new_tag;
  tag_t               iss_tag;
  tag_t               tag_out;
  tag_t               tag_sr [LATENCIA];

  // Gating with RSTa keeps req_ready low throughout reset.
  divisor_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .req   (req_valid),
    .en    (en & RSTa),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept_c  = |grant;

  // Operand and id mux of the granted requester.
  always_comb begin
    sel_num = '0;
    sel_den = '0;
    sel_id  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_num = req_num[i*TAMANYO +: TAMANYO];
        sel_den = req_den[i*TAMANYO +: TAMANYO];
        sel_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    new_tag = '0;
    if (accept_c) begin
      new_tag.valid = 1'b1;
      new_tag.id    = sel_id;
      new_tag.dz    = (sel_den == '0);
    end
  end

  // Issue register; operands hold when idle.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      iss_tag   <= '0;
    end else begin
      div_start <= accept_c;
      iss_tag   <= new_tag;
      if (accept_c) begin
        div_num <= sel_num;
        div_den <= sel_den;
      end
    end
  end

  // Tag pipeline fed from the issue stage so its output lines up with div_done.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int unsigned i = 0; i < LATENCIA; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= iss_tag;
      for (int unsigned i = 1; i < LATENCIA; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign tag_out = tag_sr[LATENCIA-1];

  always_comb begin
    any_tag_c = 1'b0;
    for (int unsigned i = 0; i < LATENCIA; i++) any_tag_c = any_tag_c | tag_sr[i].valid;
  end

  assign busy_c = accept_c | iss_tag.valid | any_tag_c;

  always_comb begin
    rsp_valid_n = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid_n[i] = tag_out.valid && (tag_out.id == ID_W'(i));
    end
  end

  // Response register with divide-by-zero substitution, plus status flags.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      rsp_valid <= '0;
      rsp_coc   <= '0;
      rsp_res   <= '0;
      rsp_dz    <= 1'b0;
      busy      <= 1'b0;
      err_tag   <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_n;
      rsp_dz    <= tag_out.valid & tag_out.dz;
      if (tag_out.valid) begin
        rsp_coc <= tag_out.dz ? '1 : div_coc;
        rsp_res <= tag_out.dz ? '0 : div_res;
      end
      busy    <= busy_c;
      err_tag <= err_tag | (div_done != tag_out.valid);
    end
  end

endmodule

// File: tb/tb_divisor_seg_planificador.sv
// Self-checking bench for divisor_seg_planificador with a behavioural divider
// and a queue-based scoreboard of expected responses.
module tb_divisor_seg_planificador;

  localparam int T = 32;
  localparam int N = 4;
  localparam int L = 2 * T + 1;

  logic           CLK = 1'b0;
  logic           RSTa = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*T-1:0] req_num = '0;
  logic [N*T-1:0] req_den = '0;
  logic [N-1:0]   req_ready;
  logic           div_start;
  logic [T-1:0]   div_num, div_den;
  logic [T-1:0]   div_coc, div_res;
  logic           div_done;
  logic [N-1:0]   rsp_valid;
  logic [T-1:0]   rsp_coc, rsp_res;
  logic           rsp_dz;
  logic           busy;
  logic           err_tag;

  always #5 CLK = ~CLK;

  divisor_seg_planificador #(.TAMANYO(T), .N_REQ(N)) dut (
    .CLK(CLK), .RSTa(RSTa), .en(en),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den), .req_ready(req_ready),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
    .rsp_valid(rsp_valid), .rsp_coc(rsp_coc), .rsp_res(rsp_res), .rsp_dz(rsp_dz),
    .busy(busy), .err_tag(err_tag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Signed truncating division; den==-1 handled apart to avoid overflow trap.
  function automatic logic [63:0] quot_rem(input logic [T-1:0] n, input logic [T-1:0] d);
    logic signed [T-1:0] sn, sd, q, r;
    sn = n; sd = d;
    if (d == '1) begin
      q = -sn; r = '0;
    end else begin
      q = sn / sd; r = sn % sd;
    end
    return {q, r};
  endfunction

  // Behavioural divider: fixed latency, garbage on divide by zero.
  logic [2*T:0] dpipe [L];
  logic         inj = 1'b0;
  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int i = 0; i < L; i++) dpipe[i] <= '0;
    end else begin
      dpipe[0] <= {div_start, (div_den == '0) ? {32'hDEADBEEF, 32'h0BAD0BAD} : quot_rem(div_num, div_den)};
      for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_done = dpipe[L-1][2*T] | inj;
  assign div_coc  = dpipe[L-1][2*T-1:T];
  assign div_res  = dpipe[L-1][T-1:0];

  typedef struct {
    int         id;
    logic [T-1:0] coc;
    logic [T-1:0] res;
    logic       dz;
    int         due;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           ptr = 0;
  logic         last_acc = 1'b0;
  logic [T-1:0] last_num = '0, last_den = '0;
  logic         exp_err = 1'b0;
  logic [N-1:0] s_valid = '0;
  logic         s_en = 1'b1;
  logic         s_inj = 1'b0;
  logic [T-1:0] s_num [N];
  logic [T-1:0] s_den [N];

  // One clock cycle: check registered outputs, drive stimulus, check grant.
  task automatic tick();
    logic [N-1:0] exp_v, exp_g;
    logic [63:0]  qr;
    int g, idx;
    exp_t e;
    @(posedge CLK); #1; cyc++;
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    chk("err_tag", 64'(err_tag), 64'(exp_err));
    chk("div_start", 64'(div_start), 64'(last_acc));
    if (last_acc) begin
      chk("div_num", 64'(div_num), 64'(last_num));
      chk("div_den", 64'(div_den), 64'(last_den));
    end
    exp_v = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_v[e.id] = 1'b1;
      chk("rsp_coc", 64'(rsp_coc), 64'(e.coc));
      chk("rsp_res", 64'(rsp_res), 64'(e.res));
      chk("rsp_dz", 64'(rsp_dz), 64'(e.dz));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    inj = s_inj;
    if (s_inj) exp_err = 1'b1;
    s_inj = 1'b0;
    en = s_en;
    req_valid = s_valid;
    for (int i = 0; i < N; i++) begin
      req_num[i*T +: T] = s_num[i];
      req_den[i*T +: T] = s_den[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (g < 0 && s_en && s_valid[idx]) g = idx;
    end
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_g));
    last_acc = (g >= 0);
    if (g >= 0) begin
      e.id  = g;
      e.dz  = (s_den[g] == '0);
      qr    = quot_rem(s_num[g], e.dz ? 32'd1 : s_den[g]);
      e.coc = e.dz ? '1 : qr[63:32];
      e.res = e.dz ? '0 : qr[31:0];
      e.due = cyc + L + 2;
      sb.push_back(e);
      last_num = s_num[g];
      last_den = s_den[g];
      ptr = (g + 1) % N;
      s_valid[g] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_outs"}, 64'({div_start, rsp_valid, rsp_dz, busy, err_tag}), 64'(0));
    chk({tag, "_data"}, {div_num, div_den} | {rsp_coc, rsp_res}, 64'(0));
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTa = 1'b0;
    req_valid = '0; s_valid = '0; inj = 1'b0; s_inj = 1'b0;
    #1;
    check_zero("rst_now");
    sb.delete(); ptr = 0; last_acc = 1'b0; exp_err = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    req_valid = '1; en = 1'b1;
    #1;
    check_zero("rst_hold");
    req_valid = '0;
    RSTa = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic issue(input int id, input logic [T-1:0] n, input logic [T-1:0] d);
    s_num[id] = n; s_den[id] = d; s_valid[id] = 1'b1;
  endtask

  function automatic logic [T-1:0] rand_den();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return T'($urandom_range(1, 20));
      default: return T'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin s_num[i] = '0; s_den[i] = 32'd1; end
    do_reset();

    // Single and signed requests.
    issue(0, 32'd100, 32'd7);
    tick();
    drain();
    issue(1, -32'sd100, 32'd7);
    tick();
    drain();

    // Fairness with all requesters held valid for 8 cycles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!s_valid[i]) issue(i, T'($urandom), T'($urandom_range(1, 99)));
      tick();
    end
    s_valid = '0;
    drain();

    // Division by zero and overflow corner.
    issue(2, 32'd5, 32'd0);
    tick();
    issue(3, 32'h80000000, 32'hFFFFFFFF);
    tick();
    drain();

    // Drain with en low.
    issue(0, 32'd77, 32'd5);
    tick();
    issue(1, 32'd9, 32'd4);
    tick();
    s_en = 1'b0;
    issue(3, 32'd1, 32'd1);
    drain();
    s_en = 1'b1;
    tick();
    drain();

    // Reset in the middle of traffic, then idle.
    for (int i = 0; i < 3; i++) begin
      issue(i, T'($urandom), rand_den());
      tick();
    end
    repeat (17) tick();
    do_reset();
    repeat (80) tick();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_valid[i] && $urandom_range(0, 3) == 0)
          issue(i, ($urandom_range(0, 7) == 0) ? 32'h80000000 : T'($urandom), rand_den());
      end
      s_en = ($urandom_range(0, 7) != 0);
      tick();
    end
    s_valid = '0;
    s_en = 1'b1;
    drain();

    // Spurious div_done must latch err_tag until reset.
    s_inj = 1'b1;
    tick();
    repeat (3) tick();
    do_reset();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
